// File: rtl/mmcm_phase_sweeper.sv
// Phase-sweep sequencer for the MMCM phase-shift stepper. It walks a signed
// step index from a start value to a stop value. For each point it loads the
// stepper, waits for its done pulse, dwells, and then pulses "settled".
module mmcm_phase_sweeper #(
    parameter int pDWELL_WIDTH = 16,
    parameter int pTIMEOUT     = 4095
) (
    input  logic                    clk_usb,
    input  logic                    reset,
    input  logic                    I_start,
    input  logic                    I_abort,
    input  logic [15:0]             I_start_index,
    input  logic [15:0]             I_stop_index,
    input  logic [15:0]             I_step,
    input  logic [pDWELL_WIDTH-1:0] I_dwell,
    output logic [15:0]             O_step_index,
    output logic                    O_load,
    input  logic                    I_done,
    output logic                    O_busy,
    output logic                    O_settled,
    output logic [15:0]             O_point,
    output logic                    O_sweep_done,
    output logic                    O_error
);

    localparam int TW = $clog2(pTIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(pTIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DWELL,
        S_NEXT,
        S_FINISH
    } state_t;

    state_t                   state_reg;
    state_t                   state_next;
    logic signed [15:0]       cur_reg;
    logic signed [15:0]       stop_reg;
    logic [15:0]              step_reg;
    logic [pDWELL_WIDTH-1:0]  dwell_reg;
    logic [pDWELL_WIDTH-1:0]  dwell_cnt_reg;
    logic [TW-1:0]            timeout_reg;
    logic                     dir_up_reg;
    logic                     abort_reg;
    logic [15:0]              point_reg;
    logic                     error_reg;
    logic [15:0]              step_index_reg;

    logic signed [17:0]       cur_wide;
    logic signed [17:0]       stop_wide;
    logic signed [17:0]       step_wide;
    logic signed [17:0]       sum_wide;
    logic                     overshoot;
    logic signed [15:0]       cur_step;

    // Next sweep index, computed wide so it cannot wrap, then clamped to stop
    always_comb begin
        step_wide = (step_reg == 16'd0) ? 18'sd1 : $signed({2'b00, step_reg});
        cur_wide  = $signed({{2{cur_reg[15]}}, cur_reg});
        stop_wide = $signed({{2{stop_reg[15]}}, stop_reg});
        sum_wide  = dir_up_reg ? (cur_wide + step_wide) : (cur_wide - step_wide);
        overshoot = dir_up_reg ? (sum_wide > stop_wide) : (sum_wide < stop_wide);
        cur_step  = overshoot ? stop_reg : $signed(sum_wide[15:0]);
    end

    // State register
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-state strobes
    always_comb begin
        state_next   = state_reg;
        O_load       = 1'b0;
        O_settled    = 1'b0;
        O_sweep_done = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (I_start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                O_load     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A zero dwell skips DWELL so settled still lands dwell+1 after done
                if (I_done) begin
                    state_next = (dwell_reg == '0) ? S_NEXT : S_DWELL;
                end else if (timeout_reg == TIMEOUT_LAST) begin
                    state_next = S_FINISH;
                end
            end
            S_DWELL: begin
                if (dwell_cnt_reg <= pDWELL_WIDTH'(1)) begin
                    state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                O_settled  = 1'b1;
                state_next = (abort_reg || (cur_reg == stop_reg)) ? S_FINISH : S_LOAD;
            end
            S_FINISH: begin
                O_sweep_done = 1'b1;
                state_next   = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Sweep datapath: latched parameters, counters, index and sticky flags
    always_ff @(posedge clk_usb or posedge reset) begin
        if (reset) begin
            cur_reg        <= '0;
            stop_reg       <= '0;
            step_reg       <= '0;
            dwell_reg      <= '0;
            dwell_cnt_reg  <= '0;
            timeout_reg    <= '0;
            dir_up_reg     <= 1'b0;
            abort_reg      <= 1'b0;
            point_reg      <= '0;
            error_reg      <= 1'b0;
            step_index_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (I_start) begin
                        cur_reg        <= $signed(I_start_index);
                        stop_reg       <= $signed(I_stop_index);
                        step_reg       <= I_step;
                        dwell_reg      <= I_dwell;
                        dir_up_reg     <= ($signed(I_stop_index) >= $signed(I_start_index));
                        point_reg      <= '0;
                        error_reg      <= 1'b0;
                        abort_reg      <= 1'b0;
                        // Index is presented from the LOAD cycle onward
                        step_index_reg <= I_start_index;
                    end
                end
                S_LOAD: begin
                    timeout_reg <= '0;
                end
                S_WAIT: begin
                    if (I_done) begin
                        dwell_cnt_reg <= dwell_reg;
                    end else if (timeout_reg == TIMEOUT_LAST) begin
                        error_reg <= 1'b1;
                    end else begin
                        timeout_reg <= timeout_reg + TW'(1);
                    end
                end
                S_DWELL: begin
                    dwell_cnt_reg <= dwell_cnt_reg - pDWELL_WIDTH'(1);
                end
                S_NEXT: begin
                    point_reg <= point_reg + 16'd1;
                    if (state_next == S_LOAD) begin
                        cur_reg        <= cur_step;
                        step_index_reg <= cur_step;
                    end
                end
                default: begin
                end
            endcase
            // Abort is only remembered here; it takes effect at the next point boundary
            if (state_reg != S_IDLE && I_abort) begin
                abort_reg <= 1'b1;
            end
        end
    end

    assign O_step_index = step_index_reg;
    assign O_point      = point_reg;
    assign O_error      = error_reg;
    assign O_busy       = (state_reg != S_IDLE) && (state_reg != S_FINISH);

endmodule
